// File: rtl/blinker_pkg.sv
// Shared types and constants for the LED burst scheduler.
package blinker_pkg;

    localparam int unsigned N_REQ            = 4;
    localparam int unsigned IDX_W            = 2;
    localparam int unsigned CNT_FIELD_W      = 4;
    localparam int unsigned TICK_MAX_DEFAULT = 50 * 1024 * 1024;
    localparam int unsigned CNT_W_DEFAULT    = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_e;

    // First set request bit searching upward from ptr+1, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = IDX_W'(32'(ptr) + i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/blinker_tick_counter.sv
// Enable-gated half-period counter; tick marks the last cycle of a half-period.
module blinker_tick_counter
    import blinker_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned TICK_MAX = TICK_MAX_DEFAULT
) (
    input  logic system1000,
    input  logic system1000_rstn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_MAX - 1);

    logic [CNT_W-1:0] count;

    assign tick = en && (count == LAST);

    // Wraps to zero on the tick cycle so the count never reaches TICK_MAX.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/blinker_burst_sched.sv
// Round-robin scheduler sharing one LED among four burst requesters.
module blinker_burst_sched
    import blinker_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned TICK_MAX = TICK_MAX_DEFAULT
) (
    input  logic                           system1000,
    input  logic                           system1000_rstn,
    input  logic [N_REQ-1:0]               req_i,
    input  logic [N_REQ*CNT_FIELD_W-1:0]   cnt_i,
    output logic [N_REQ-1:0]               grant_o,
    output logic [N_REQ-1:0]               done_o,
    output logic                           led_o,
    output logic                           busy_o
);

    state_e                 state;
    state_e                 state_nxt;
    logic [CNT_FIELD_W-1:0] rem;
    logic [CNT_FIELD_W-1:0] rem_nxt;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_ptr_nxt;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       sel_nxt;
    logic [N_REQ-1:0]       grant_nxt;
    logic [N_REQ-1:0]       done_nxt;
    logic                   led_nxt;
    logic                   busy_nxt;
    logic                   cnt_en;
    logic                   cnt_clr;
    logic                   tick;
    logic [IDX_W-1:0]       pick;
    logic [CNT_FIELD_W-1:0] pick_cnt;

    assign pick     = rr_pick(req_i, rr_ptr);
    assign pick_cnt = cnt_i[32'(pick)*CNT_FIELD_W +: CNT_FIELD_W];

    blinker_tick_counter #(
        .CNT_W    (CNT_W),
        .TICK_MAX (TICK_MAX)
    ) u_tick (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .en              (cnt_en),
        .clr             (cnt_clr),
        .tick            (tick)
    );

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, latched burst context and registered output values.
    always_comb begin
        state_nxt  = state;
        rem_nxt    = rem;
        rr_ptr_nxt = rr_ptr;
        sel_nxt    = sel;
        grant_nxt  = grant_o;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;

        case (state)
            IDLE: begin
                if (|req_i) begin
                    sel_nxt   = pick;
                    grant_nxt = N_REQ'(1) << pick;
                    rem_nxt   = pick_cnt;
                    cnt_clr   = 1'b1;
                    state_nxt = (pick_cnt != '0) ? ON : DONE;
                end
            end
            ON: begin
                cnt_en = 1'b1;
                if (tick) begin
                    state_nxt = OFF;
                end
            end
            OFF: begin
                cnt_en = 1'b1;
                if (tick) begin
                    rem_nxt   = rem - CNT_FIELD_W'(1);
                    state_nxt = (rem == CNT_FIELD_W'(1)) ? DONE : ON;
                end
            end
            DONE: begin
                rr_ptr_nxt = sel;
                grant_nxt  = '0;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        led_nxt  = (state_nxt == ON);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE) ? grant_nxt : '0;
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            rem     <= '0;
            rr_ptr  <= IDX_W'(N_REQ - 1);
            sel     <= '0;
            grant_o <= '0;
            done_o  <= '0;
            led_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            rem     <= rem_nxt;
            rr_ptr  <= rr_ptr_nxt;
            sel     <= sel_nxt;
            grant_o <= grant_nxt;
            done_o  <= done_nxt;
            led_o   <= led_nxt;
            busy_o  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_blinker_burst_sched.sv
// Randomized bench for blinker_burst_sched against a burst-timeline reference model.
module tb_blinker_burst_sched;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 3;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [3:0]  req;
    logic [15:0] cnt;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        led;
    logic        busy;

    blinker_burst_sched #(
        .CNT_W    (CW),
        .TICK_MAX (T)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .req_i           (req),
        .cnt_i           (cnt),
        .grant_o         (grant),
        .done_o          (done),
        .led_o           (led),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: one burst = grant edge m_start, length 2*count*T, DONE at offset m_len.
    bit m_active;
    int m_start;
    int m_len;
    int m_idx;
    int m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int i = 1; i <= 4; i++) begin
            int j;
            j = (p + i) % 4;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_active = 1'b0;
        m_start  = 0;
        m_len    = 0;
        m_idx    = 0;
        m_ptr    = 3;
    endtask

    task automatic model_edge();
        cyc++;
        if (m_active && cyc >= m_start + m_len + 2) begin
            m_ptr    = m_idx;
            m_active = 1'b0;
        end
        if (!m_active && req != 4'b0) begin
            logic [3:0] k;
            m_idx    = rr_model(req, m_ptr);
            k        = cnt[4*m_idx +: 4];
            m_len    = 2 * int'(k) * int'(T);
            m_start  = cyc;
            m_active = 1'b1;
        end
    endtask

    task automatic compare_all();
        int         off;
        bit         inb;
        logic [3:0] eg;
        off = cyc - m_start;
        inb = m_active && off <= m_len;
        eg  = inb ? 4'(1 << m_idx) : 4'b0;
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("led", 32'(led), 32'(inb && off < m_len && ((off / int'(T)) % 2 == 0)));
        check_eq("done", 32'(done), 32'((inb && off == m_len) ? eg : 4'b0));
        check_eq("busy", 32'(busy), 32'(inb));
        if (inb) begin
            check_eq("count", 32'(dut.u_tick.count), 32'(off % int'(T)));
            check_eq("tick", 32'(dut.u_tick.tick),
                     32'(off < m_len && (off % int'(T)) == int'(T) - 1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drive(input logic [3:0] r, input logic [15:0] c);
        req = r;
        cnt = c;
    endtask

    // Asynchronous reset in the middle of a clock phase; outputs must drop at once.
    task automatic async_reset();
        #2;
        rstn = 1'b0;
        #1;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        m_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [3:0] prev_grant;
        logic [3:0] rr_seen[$];
        logic [3:0] rr_exp[5];
        logic [15:0] c;

        m_reset();
        drive(4'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_grant", 32'(grant), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        check_eq("reset_led", 32'(led), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_count", 32'(dut.u_tick.count), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Single two-flash burst from requester 0, request pulsed for one cycle.
        drive(4'b0001, 16'h0002);
        step();
        drive(4'b0, 16'h0);
        run(24);

        // Zero-count burst from requester 2.
        drive(4'b0100, 16'h0000);
        step();
        drive(4'b0, 16'h0);
        run(4);

        // Round-robin with all requesters held and counts of one.
        async_reset();
        drive(4'b1111, 16'h1111);
        prev_grant = 4'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (grant != 4'b0 && prev_grant == 4'b0) rr_seen.push_back(grant);
            prev_grant = grant;
        end
        drive(4'b0, 16'h0);
        run(12);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check_eq("rr_bursts", 32'(rr_seen.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < rr_seen.size(); i++) begin
            check_eq("rr_order", 32'(rr_seen[i]), 32'(rr_exp[i]));
        end

        // Count and request changes mid-burst are ignored.
        drive(4'b0010, 16'h0020);
        step();
        run(3);
        drive(4'b0000, 16'h00F0);
        run(20);

        // Reset during ON; pending requester 0 wins first afterwards.
        drive(4'b0001, 16'h0003);
        run(3);
        async_reset();
        drive(4'b0101, 16'h0101);
        step();
        check_eq("post_reset_grant", 32'(grant), 32'h1);
        run(25);
        drive(4'b0, 16'h0);
        run(6);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            c = 16'h0;
            for (int f = 0; f < 4; f++) begin
                c[4*f +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 3));
            end
            drive(($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom_range(0, 15)), c);
            step();
        end
        drive(4'b0, 16'h0);
        run(140);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blinker_burst_sched.md
# blinker_burst_sched

Round-robin scheduler that shares the single LED and its tick counter among four requesters. Each requester asks for a burst of N flashes. The block arbitrates, times each on/off half-period with an internal enable-gated tick counter, drives the LED, and returns a per-requester done pulse. It sits between the control logic that wants visible status flashes and the board LED, in the system1000 clock domain.

## Interface
Parameters:
- CNT_W, 26, tick counter width
- TICK_MAX, 52428800 (50*1024*1024), cycles per LED half-period; legal range 2 .. 2^CNT_W

Ports:
- system1000  in  1  clock, rising edge
- system1000_rstn  in  1  reset system1000_rstn, asynchronous, active-low
- req_i  in  4  burst request, one bit per requester, level
- cnt_i  in  16  flash count, requester k uses bits [4k+3:4k], 0..15
- grant_o  out  4  one-hot, the requester currently being served
- done_o  out  4  one-cycle pulse on the served bit at burst end
- led_o  out  1  LED drive, 1 = on
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE, ON, OFF, DONE.
- IDLE:
  - If req_i is nonzero, pick the first set bit searching upward from rr_ptr+1 (mod 4).
  - Latch that requester's cnt_i into rem and set grant_o.
  - If the latched count is nonzero, go to ON; if it is 0, go to DONE.
  - The tick counter is cleared on this transition.
- ON: led_o = 1, counter enabled; on tick go to OFF.
- OFF: led_o = 0, counter enabled; on tick decrement rem. If rem was 1, go to DONE, else go to ON.
- DONE:
  - done_o = grant_o for one cycle.
  - rr_ptr takes the served index.
  - grant_o clears on exit; go to IDLE.
- Tick counter:
  - Increments by 1 each enabled cycle.
  - tick is combinational when count == TICK_MAX-1, and count wraps to 0 on that cycle.
  - The counter holds its value when disabled and has a synchronous clear.
  - Arithmetic is CNT_W bits, unsigned.
- Latching:
  - cnt_i and the requester choice are latched at grant.
  - Changes to req_i or cnt_i during a burst are ignored.
  - Dropping req_i mid-burst does not abort the burst.
- A requester still holding req_i after its done_o is served again only after the other pending requesters have each been served (round-robin fairness).
- Reset:
  - Values: state = IDLE, rr_ptr = 3 (first search starts at requester 0), rem = 0, counter = 0, grant_o = 0, done_o = 0, led_o = 0, busy_o = 0.
  - Reset asserted mid-burst abandons the burst immediately, with no done_o.

## Timing
- Request seen in IDLE at cycle t:
  - grant_o, busy_o and state ON (led_o = 1) appear at t+1.
  - The counter is 0 at t+1.
- Each half-period lasts exactly TICK_MAX cycles.
- For count k ≥ 1, done_o is high at cycle t+1+2·k·TICK_MAX, in the DONE state.
- For count 0, done_o is high at t+1, with led_o low throughout.
- After DONE the block spends at least one cycle in IDLE, so the next grant is no earlier than 2 cycles after done_o.
- Outputs are registered or decoded from the state register only; there is no combinational path from req_i to any output.

## Structure
- Shared package blinker_pkg holds:
  - the state enum (IDLE, ON, OFF, DONE)
  - N_REQ = 4 and CNT_FIELD_W = 4
  - TICK_MAX_DEFAULT = 50*1024*1024 and CNT_W_DEFAULT = 26
- One sub-module, blinker_tick_counter:
  - parameters CNT_W and TICK_MAX
  - ports: clock, reset, en, clr, tick
- The scheduler holds the FSM, the round-robin search, rem and rr_ptr.

## Test plan
All scenarios use TICK_MAX = 4, CNT_W = 3.
- Single request: req_i = 0001, cnt[0] = 2, pulsed at t.
  - grant_o = 0001 at t+1.
  - led_o pattern is 1111 0000 1111 0000.
  - done_o = 0001 at t+17, busy_o low at t+18.
- Zero count: req_i = 0100, cnt[2] = 0.
  - grant_o = done_o = 0100 at t+1, led_o never high.
  - Back in IDLE at t+2.
- Round-robin: req_i = 1111 held, all counts = 1 after reset.
  - Grants are served in order 0001, 0010, 0100, 1000, 0001.
  - Each burst is 8 cycles plus 2 cycles of overhead.
- Latching: during a burst for requester 1, change cnt[1] to 15 and drop req_i[1].
  - The burst still runs its original count and done_o[1] fires.
- Reset mid-burst: assert system1000_rstn low during ON.
  - led_o, grant_o and busy_o go to 0 immediately (asynchronously), with no done_o.
  - After release, a pending req_i[0] is granted first.
- Wrap check: with the counter observed inside ON, tick is high exactly when count = 3.
  - Count returns to 0 on the next cycle, never reaching 4.
